regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: requester 0 is ALU writeback and requester 1 is load/multdiv writeback. The block arbitrates round-robin and registers the winning write onto the regfile's ctrl_writeEn / ctrl_writeReg / data_writeReg inputs. It also suppresses writes to register 0 and keeps a saturating count of contention cycles for performance debug. It sits between the writeback stage and the regfile.

---
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between ALU writeback
//   (requester 0) and load/multdiv writeback (requester 1). Round-robin
//   arbitration, one registered write per cycle, optional suppression of
//   writes to register 0, and a saturating contention counter for debug.
//
// Ports
//   clock, ctrl_reset             clock, synchronous active-high reset
//   reqN_valid/reg/data/ready     writeback requester N (N = 0, 1)
//   ctrl_writeEn/writeReg         registered regfile write enable / index
//   data_writeReg                 registered regfile write data
//   grant_id                      requester whose write is on the port
//   conflict_count                saturating count of both-valid cycles
module regfile_wb_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int DROP_R0 = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              ctrl_writeEn,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              grant_id,
  output logic [CNT_W-1:0]  conflict_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_last_grant;
  logic              r_write_en;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_grant_id;
  logic [CNT_W-1:0]  r_conflict_count;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic              w_both;
  logic              w_drop;
  logic [ADDR_W-1:0] w_win_reg;
  logic [DATA_W-1:0] w_win_data;

  assign w_both = req0_valid & req1_valid;

  // Under contention the requester that did not win last time goes next,
  // so no valid request waits more than one cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!ctrl_reset) begin
      if (w_both) begin
        w_gnt0 = r_last_grant;
        w_gnt1 = ~r_last_grant;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign w_xfer     = w_gnt0 | w_gnt1;
  assign w_win_reg  = w_gnt1 ? req1_reg  : req0_reg;
  assign w_win_data = w_gnt1 ? req1_data : req0_data;
  // A write to r0 still handshakes; only the enable is withheld.
  assign w_drop     = (DROP_R0 != 0) && (w_win_reg == '0);

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_last_grant     <= 1'b1;
      r_write_en       <= 1'b0;
      r_write_reg      <= '0;
      r_write_data     <= '0;
      r_grant_id       <= 1'b0;
      r_conflict_count <= '0;
    end else begin
      r_write_en <= w_xfer & ~w_drop;
      if (w_xfer) begin
        r_write_reg  <= w_win_reg;
        r_write_data <= w_win_data;
        r_grant_id   <= w_gnt1;
        r_last_grant <= w_gnt1;
      end
      if (w_both && (r_conflict_count != CNT_MAX)) begin
        r_conflict_count <= r_conflict_count + CNT_W'(1);
      end
    end
  end

  assign req0_ready     = w_gnt0;
  assign req1_ready     = w_gnt1;
  assign ctrl_writeEn   = r_write_en;
  assign ctrl_writeReg  = r_write_reg;
  assign data_writeReg  = r_write_data;
  assign grant_id       = r_grant_id;
  assign conflict_count = r_conflict_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        grant_id;
  logic [7:0]  conflict_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .DROP_R0(1), .CNT_W(8)) dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .req0_valid     (req0_valid),
    .req0_reg       (req0_reg),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_reg       (req1_reg),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .ctrl_writeEn   (ctrl_writeEn),
    .ctrl_writeReg  (ctrl_writeReg),
    .data_writeReg  (data_writeReg),
    .grant_id       (grant_id),
    .conflict_count (conflict_count)
  );

  // Behavioural regfile downstream of the arbiter: r0 reads as zero and the
  // whole file clears while the core is in reset.
  logic [31:0] rf [32];
  always @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (ctrl_writeEn && ctrl_writeReg != 5'd0) begin
      rf[ctrl_writeReg] <= data_writeReg;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [4:0]  a0_reg  [3] = '{5'd1, 5'd2, 5'd0};
  logic [31:0] a0_data [3] = '{32'h11111111, 32'h22222222, 32'h0};
  logic [4:0]  a1_reg  [3] = '{5'd3, 5'd4, 5'd0};
  logic [31:0] a1_data [3] = '{32'h33333333, 32'h44444444, 32'h0};
  logic        e_gnt   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [4:0]  e_reg   [4] = '{5'd1, 5'd3, 5'd2, 5'd4};
  logic [31:0] e_data  [4] = '{32'h11111111, 32'h33333333, 32'h22222222, 32'h44444444};

  initial begin
    int i0, i1;
    logic g0, g1;
    ctrl_reset = 1'b1;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;

    // Reset for two cycles, then release.
    tick();
    tick();
    ctrl_reset = 1'b0;
    #1;
    chk("rst_we",    ctrl_writeEn,   0);
    chk("rst_reg",   ctrl_writeReg,  0);
    chk("rst_data",  data_writeReg,  0);
    chk("rst_gid",   grant_id,       0);
    chk("rst_cnt",   conflict_count, 0);
    // First tie favours requester 0; withdrawn before any edge.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("tie_rdy0", req0_ready, 1);
    chk("tie_rdy1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Requester 0 alone writes r5.
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'h00364908;
    #1;
    chk("solo_rdy0", req0_ready, 1);
    chk("solo_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("solo_we",   ctrl_writeEn,  1);
    chk("solo_reg",  ctrl_writeReg, 5);
    chk("solo_data", data_writeReg, 32'h00364908);
    chk("solo_gid",  grant_id,      0);
    tick();
    chk("solo_rf5",  rf[5],         32'h00364908);

    // Contention: re-reset so the first tie goes to requester 0 again.
    // Requester 0 finishes after the third edge, so the fourth cycle has
    // only requester 1 pending: three contention cycles in total.
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    i0 = 0; i1 = 0;
    for (int k = 0; k < 4; k++) begin
      req0_valid = (i0 < 2); req0_reg = a0_reg[i0]; req0_data = a0_data[i0];
      req1_valid = (i1 < 2); req1_reg = a1_reg[i1]; req1_data = a1_data[i1];
      #1;
      g0 = req0_ready; g1 = req1_ready;
      chk($sformatf("rr%0d_rdy0", k), g0, (e_gnt[k] == 1'b0));
      chk($sformatf("rr%0d_rdy1", k), g1, (e_gnt[k] == 1'b1));
      tick();
      if (g0) i0++;
      if (g1) i1++;
      chk($sformatf("rr%0d_we", k),   ctrl_writeEn,  1);
      chk($sformatf("rr%0d_gid", k),  grant_id,      e_gnt[k]);
      chk($sformatf("rr%0d_reg", k),  ctrl_writeReg, e_reg[k]);
      chk($sformatf("rr%0d_data", k), data_writeReg, e_data[k]);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rr_cnt", conflict_count, 3);
    chk("rr_rf1", rf[1], 32'h11111111);
    chk("rr_rf2", rf[2], 32'h22222222);
    chk("rr_rf3", rf[3], 32'h33333333);
    chk("rr_rf4", rf[4], 32'h44444444);
    chk("rr_we_idle", ctrl_writeEn, 0);

    // Requester 1 writes r0: handshake completes but the enable is withheld.
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hDEADBEEF;
    #1;
    chk("r0_rdy1", req1_ready, 1);
    chk("r0_rdy0", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    chk("r0_gid",  grant_id,      1);
    chk("r0_we",   ctrl_writeEn,  0);
    chk("r0_reg",  ctrl_writeReg, 0);
    chk("r0_data", data_writeReg, 32'hDEADBEEF);
    tick();
    chk("r0_rf0",  rf[0],         32'h0);

    // Saturation: counter is at 3, reaches 255 after 252 contention edges.
    req0_valid = 1'b1; req0_reg = 5'd8; req0_data = 32'hA0A0A0A0;
    req1_valid = 1'b1; req1_reg = 5'd9; req1_data = 32'hB0B0B0B0;
    #1;
    chk("sat_rdy0", req0_ready, 1);
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 1)   chk("sat_gid1", grant_id, 0);
      if (k == 2)   chk("sat_gid2", grant_id, 1);
      if (k == 251) chk("sat_cnt251", conflict_count, 254);
      if (k == 252) chk("sat_cnt252", conflict_count, 255);
    end
    chk("sat_cnt300", conflict_count, 255);
    chk("sat_we",     ctrl_writeEn,   1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();

    // Reset right after requester 0 is accepted for r7.
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'h0000ABCD;
    #1;
    chk("rip_rdy0", req0_ready, 1);
    tick();
    chk("rip_we_pre", ctrl_writeEn, 1);
    ctrl_reset = 1'b1;
    req1_valid = 1'b1; req1_reg = 5'd6; req1_data = 32'h66666666;
    #1;
    chk("rip_rdy0_rst", req0_ready, 0);
    chk("rip_rdy1_rst", req1_ready, 0);
    tick();
    chk("rip_we",  ctrl_writeEn,   0);
    chk("rip_cnt", conflict_count, 0);
    chk("rip_rf7", rf[7],          32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    ctrl_reset = 1'b0;
    tick();
    chk("rip_we_post", ctrl_writeEn, 0);
    chk("rip_rf7_post", rf[7], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
